// File: rtl/cache_pkg.sv
// Shared widths, address field layout and write-port payload for the direct-mapped data cache.
package cache_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned TAG_W    = 8;
  localparam int unsigned INDEX_W  = 6;
  localparam int unsigned OFFSET_W = 2;

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned WORDS = 1 << OFFSET_W;

  localparam int unsigned OFFSET_LSB = 0;
  localparam int unsigned INDEX_LSB  = OFFSET_W;
  localparam int unsigned TAG_LSB    = OFFSET_W + INDEX_W;

  // CPU address as {tag, index, offset}
  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } addr_t;

  // Single write into the line array; replace retags the line and drops its other words
  typedef struct packed {
    logic                en;
    logic                replace;
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic [DATA_W-1:0]   data;
  } wr_req_t;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[TAG_LSB +: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] index_of(input logic [ADDR_W-1:0] addr);
    return addr[INDEX_LSB +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] offset_of(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_LSB +: OFFSET_W];
  endfunction

  function automatic logic [WORDS-1:0] word_mask(input logic [OFFSET_W-1:0] offset);
    return WORDS'(1) << offset;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Tag/valid/data storage for the cache: async-cleared valid bits, combinational read, one write port.
module cache_line_array
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic [TAG_W-1:0]    rd_tag_c,
  output logic                rd_valid_c,
  output logic [DATA_W-1:0]   rd_data_c,
  input  wr_req_t             wr
);

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES][WORDS];
  logic [WORDS-1:0]  valid_q  [LINES];

  // Only the valid bits carry reset; stale tags/data are harmless behind them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '{default: '0};
    end else if (wr.en) begin
      if (wr.replace) begin
        valid_q[wr.index] <= word_mask(wr.offset);
      end else begin
        valid_q[wr.index] <= valid_q[wr.index] | word_mask(wr.offset);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr.en) begin
      data_mem[wr.index][wr.offset] <= wr.data;
      if (wr.replace) begin
        tag_mem[wr.index] <= wr.tag;
      end
    end
  end

  assign rd_tag_c   = tag_mem[rd_index];
  assign rd_valid_c = valid_q[rd_index][rd_offset];
  assign rd_data_c  = data_mem[rd_index][rd_offset];

endmodule

// File: rtl/cache.sv
// Direct-mapped write-through, write-allocate data cache: zero-latency lookup, fill/store on the clock edge.
module cache
  import cache_pkg::*;
(
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              hit,
  input  logic              memory_write_en
);

  addr_t             addr_f;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              tag_match;
  wr_req_t           wr;

  assign addr_f = addr_t'(addr_in);

  cache_line_array u_lines (
    .clk        (clk_100),
    .rst_n      (rst_n),
    .rd_index   (addr_f.index),
    .rd_offset  (addr_f.offset),
    .rd_tag_c   (rd_tag),
    .rd_valid_c (rd_valid),
    .rd_data_c  (rd_data),
    .wr         (wr)
  );

  // Lookup, miss pass-through and update decision; every store or miss writes the addressed word
  always_comb begin
    tag_match = 1'b0;
    hit       = 1'b0;
    data_out  = data_in;
    addr_out  = addr_in;
    wr        = '0;

    tag_match = (rd_tag == addr_f.tag);
    hit       = rd_valid && tag_match;
    if (hit) begin
      data_out = rd_data;
    end

    wr.en      = memory_write_en || !hit;
    wr.replace = !tag_match;
    wr.tag     = addr_f.tag;
    wr.index   = addr_f.index;
    wr.offset  = addr_f.offset;
    wr.data    = data_in;
  end

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for cache: directed vector table, reset corner sequences, randomized run vs. an address-keyed model.
module tb_cache;

  logic        clk_100;
  logic        rst_n;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [15:0] addr_in;
  logic [15:0] addr_out;
  logic        hit;
  logic        memory_write_en;

  int n_vec;
  int n_miss;

  cache dut (
    .clk_100         (clk_100),
    .rst_n           (rst_n),
    .data_in         (data_in),
    .data_out        (data_out),
    .addr_in         (addr_in),
    .addr_out        (addr_out),
    .hit             (hit),
    .memory_write_en (memory_write_en)
  );

  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] din;
    logic        exp_hit;
    logic [15:0] exp_dout;
  } vec_t;

  // Model: set of cached word addresses -> data; a line holds words of only one tag
  logic [15:0] mdl [logic [15:0]];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (addr %h t=%0t)", name, got, exp, addr_in, $time);
    end
  endtask

  function automatic logic [5:0] idx(input logic [15:0] a);
    return a[7:2];
  endfunction

  task automatic mdl_update(input logic [15:0] a, input logic [15:0] d);
    logic [15:0] victims [$];
    foreach (mdl[k]) begin
      if (idx(k) == idx(a) && k[15:8] != a[15:8]) victims.push_back(k);
    end
    foreach (victims[i]) mdl.delete(victims[i]);
    mdl[a] = d;
  endtask

  // Drive one CPU access mid-cycle and check the combinational outputs before the next edge
  task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d,
                        input logic eh, input logic [15:0] ed, input string name);
    @(negedge clk_100);
    memory_write_en = we;
    addr_in         = a;
    data_in         = d;
    #1;
    check({name, ".hit"}, 16'(hit), 16'(eh));
    check({name, ".data_out"}, data_out, ed);
    check({name, ".addr_out"}, addr_out, a);
  endtask

  task automatic do_reset();
    @(negedge clk_100);
    rst_n = 1'b0;
    @(negedge clk_100);
    rst_n = 1'b1;
  endtask

  vec_t vecs [22];

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n           = 1'b0;
    memory_write_en = 1'b0;
    addr_in         = 16'hF005;
    data_in         = 16'h0000;

    vecs[0]  = '{1'b0, 16'hF005, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 16'hF005, 16'h1234, 1'b1, 16'h0000};
    vecs[2]  = '{1'b0, 16'h1234, 16'hBEEF, 1'b0, 16'hBEEF};
    vecs[3]  = '{1'b0, 16'h1234, 16'h5555, 1'b1, 16'hBEEF};
    vecs[4]  = '{1'b1, 16'h1234, 16'hCAFE, 1'b1, 16'hBEEF};
    vecs[5]  = '{1'b0, 16'h1234, 16'h0000, 1'b1, 16'hCAFE};
    vecs[6]  = '{1'b1, 16'h1235, 16'h7777, 1'b0, 16'h7777};
    vecs[7]  = '{1'b0, 16'h1235, 16'h0000, 1'b1, 16'h7777};
    vecs[8]  = '{1'b0, 16'h1236, 16'h0ABC, 1'b0, 16'h0ABC};
    vecs[9]  = '{1'b0, 16'h2234, 16'h2222, 1'b0, 16'h2222};
    vecs[10] = '{1'b0, 16'h2234, 16'h0000, 1'b1, 16'h2222};
    vecs[11] = '{1'b0, 16'h2235, 16'h3333, 1'b0, 16'h3333};
    vecs[12] = '{1'b0, 16'h1235, 16'h4444, 1'b0, 16'h4444};
    vecs[13] = '{1'b0, 16'h1234, 16'h5151, 1'b0, 16'h5151};
    vecs[14] = '{1'b0, 16'h2234, 16'h6161, 1'b0, 16'h6161};
    vecs[15] = '{1'b0, 16'h00FC, 16'hAAAA, 1'b0, 16'hAAAA};
    vecs[16] = '{1'b0, 16'h0000, 16'hBBBB, 1'b0, 16'hBBBB};
    vecs[17] = '{1'b0, 16'h00FC, 16'h0000, 1'b1, 16'hAAAA};
    vecs[18] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBBBB};
    vecs[19] = '{1'b0, 16'h01FC, 16'hCCCC, 1'b0, 16'hCCCC};
    vecs[20] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBBBB};
    vecs[21] = '{1'b0, 16'h00FC, 16'hDDDD, 1'b0, 16'hDDDD};

    // Outputs while held in reset
    #2;
    check("reset.hit", 16'(hit), 16'h0000);
    check("reset.data_out", data_out, 16'h0000);
    check("reset.addr_out", addr_out, 16'hF005);
    addr_in = 16'hABCD;
    data_in = 16'h4321;
    #1;
    check("reset.addr_follow", addr_out, 16'hABCD);
    check("reset.dout_follow", data_out, 16'h4321);
    @(negedge clk_100);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].exp_hit, vecs[i].exp_dout,
             $sformatf("vec%0d", i));
    end

    // Async reset between edges: hit drops at once, edges during reset change nothing
    @(negedge clk_100);
    memory_write_en = 1'b0;
    addr_in = 16'h0000;
    data_in = 16'h1357;
    #1;
    check("pre_rst.hit", 16'(hit), 16'h0001);
    check("pre_rst.data_out", data_out, 16'hBBBB);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst.hit", 16'(hit), 16'h0000);
    check("mid_rst.data_out", data_out, 16'h1357);
    check("mid_rst.addr_out", addr_out, 16'h0000);
    @(negedge clk_100);
    memory_write_en = 1'b1;
    addr_in = 16'h5678;
    data_in = 16'h9999;
    @(negedge clk_100);
    rst_n = 1'b1;
    memory_write_en = 1'b0;
    #1;
    check("post_rst.store_ignored", 16'(hit), 16'h0000);
    access(1'b0, 16'h0000, 16'h0101, 1'b0, 16'h0101, "post_rst.a0000");
    access(1'b0, 16'h1235, 16'h0202, 1'b0, 16'h0202, "post_rst.a1235");
    access(1'b0, 16'h00FC, 16'h0303, 1'b0, 16'h0303, "post_rst.a00FC");
    access(1'b0, 16'h2234, 16'h0404, 1'b0, 16'h0404, "post_rst.a2234");

    // Randomized run against the model, with occasional mid-cycle reset pulses
    do_reset();
    mdl.delete();
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] a;
      logic [15:0] d;
      logic        we;
      logic        eh;
      logic [15:0] ed;
      logic [7:0]  tags [4];
      tags[0] = 8'h12; tags[1] = 8'h34; tags[2] = 8'hF0; tags[3] = 8'h01;
      a  = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3))};
      d  = 16'($urandom);
      we = ($urandom_range(0, 3) == 0);
      eh = mdl.exists(a);
      ed = eh ? mdl[a] : d;
      access(we, a, d, eh, ed, "rand");
      if ($urandom_range(0, 63) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        check("rand_rst.hit", 16'(hit), 16'h0000);
        check("rand_rst.data_out", data_out, d);
        rst_n = 1'b1;
        mdl.delete();
        eh = 1'b0;
      end
      if (we || !eh) mdl_update(a, d);
    end

    @(negedge clk_100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cache.md
Name: cache

Overview:
- Direct-mapped, write-through, write-allocate data cache for the 16-bit processor, sitting between the CPU memory port and main memory.
- Looks up each CPU address combinationally and forwards the address to main memory.
- On a miss, it fills from the memory word presented on data_in. On a CPU write, it updates the cached copy while memory is written in parallel.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, address width
- TAG_W, 8, tag field width (addr[15:8])
- INDEX_W, 6, set index width (addr[7:2]); 64 lines
- OFFSET_W, 2, word-in-line offset width (addr[1:0]); 4 words per line

Ports:
- clk_100  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- data_in  in  16  CPU write data when memory_write_en=1; otherwise main-memory read (fill) data
- data_out  out  16  read data to CPU
- addr_in  in  16  CPU address {tag[7:0], index[5:0], offset[1:0]}
- addr_out  out  16  address forwarded to main memory
- hit  out  1  1 = addr_in word present and valid in cache
- memory_write_en  in  1  1 = CPU store this cycle

Behaviour:
- Storage
  - 64 lines, each with one 8-bit tag, four 16-bit data words and four per-word valid bits.
  - Tag and data arrays are not reset.
  - rst_n=0 asynchronously clears all 256 valid bits.
- Combinational lookup, with zero latency:
  - hit = valid[index][offset] && (tag[index] == addr_in[15:8]).
  - data_out = data[index][offset] when hit=1, else data_in (miss pass-through of memory data).
  - addr_out = addr_in at all times, including during reset.
- Reset values: hit=0 and data_out=data_in, both following from all-invalid. addr_out=addr_in.
- Rising edge of clk_100 with rst_n=1: an update occurs when memory_write_en=1 (store) or hit=0 (read miss fill).
  - Update when the stored tag matches: write data[index][offset] <= data_in and set valid[index][offset].
  - Update when the stored tag differs: tag[index] <= addr_in[15:8], clear the other three valid bits of that line, write the word, set its valid bit.
  - Read hit (memory_write_en=0, hit=1): no state change.
- Store on hit overwrites the cached word. Store on miss allocates the word. Memory is always written externally using addr_out/data_in (write-through), so there is no dirty state.
- Visibility: a filled or stored word produces hit=1 and data_out equal to the new data from the cycle after the edge.
- rst_n asserted mid-operation: valid bits clear immediately and hit drops to 0 in the same cycle. No partial update occurs at an edge while rst_n=0.
- Simultaneous reset release and clock edge: the edge is ignored (valid bits stay 0).
- There are no handshakes or stalls. Main memory must present read data on data_in in the same cycle as a miss.

Decomposition:
- Shared package cache_pkg holds:
  - DATA_W, ADDR_W, TAG_W, INDEX_W, OFFSET_W
  - field-slice helpers or localparams for the tag/index/offset bit positions
- One natural sub-module, cache_line_array: tag/valid/data storage with asynchronous valid clear, a combinational read port, and a single write port with a tag-replace flag.
- Top-level cache holds the hit compare, the update decision and the output muxing.

Test Plan:
- Cold miss: rst_n pulse, addr_in=0xF005, data_in=0x0000, memory_write_en=0 -> hit=0, data_out=0x0000, addr_out=0xF005. After the next edge: hit=1, data_out=0x0000.
- Fill then read hit: addr_in=0x1234, data_in=0xBEEF (miss), one edge, then data_in=0x5555 -> hit=1, data_out=0xBEEF (not 0x5555). addr_out=0x1234 throughout.
- Store hit/miss:
  - memory_write_en=1, addr_in=0x1234, data_in=0xCAFE, one edge, then memory_write_en=0 -> hit=1, data_out=0xCAFE.
  - Store to invalid 0x1235 -> that word becomes valid; 0x1236 stays miss.
- Conflict replacement: fill 0x1234 (0xBEEF) and 0x1235 (0x1111), then fill 0x2234 (0x2222) -> 0x2234 hit with 0x2222; 0x1234 and 0x1235 both miss; 0x2235 misses.
- Async reset mid-run: after valid fills, drop rst_n between clock edges -> hit goes 0 immediately, data_out=data_in. After release, every previously filled address misses.
- Index isolation: fill 0x00FC (index 63) and 0x0000 (index 0) -> both hit independently. Filling 0x01FC evicts only index 63.
